// File: rtl/tff_cascade_pkg.sv
// rtl/tff_cascade_pkg.sv - shared constants for the cascaded T flip-flop chain
package tff_cascade_pkg;

  localparam int STAGES_MIN     = 1;
  localparam int STAGES_MAX     = 32;
  localparam int STAGES_DEFAULT = 2;

endpackage : tff_cascade_pkg

// File: rtl/tff_cascade_t_ff_cell.sv
// rtl/tff_cascade_t_ff_cell.sv - single T flip-flop, async active-low clear
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : t_ff_cell

// File: rtl/tff_cascade.sv
// rtl/tff_cascade.sv - STAGES T flip-flops in series; each stage's output toggles the next
module tff_cascade
  import tff_cascade_pkg::*;
#(
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  output logic q
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("tff_cascade: STAGES out of range");
  end

  logic [STAGES-1:0] s;

  // Every cell sees the pre-edge value of its predecessor, so all stages
  // update together rather than rippling.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      t_ff_cell u_cell (
        .clk (clk),
        .rst (rst),
        .t   (data),
        .q   (s[gi])
      );
    end else begin : g_rest
      t_ff_cell u_cell (
        .clk (clk),
        .rst (rst),
        .t   (s[gi-1]),
        .q   (s[gi])
      );
    end
  end

  assign q = s[STAGES-1];

endmodule : tff_cascade

// File: tb/tb_tff_cascade.sv
// tb/tb_tff_cascade.sv - directed scoreboard bench for the two-stage cascade
module tb_tff_cascade;

  logic clk;
  logic rst;
  logic data;
  logic q;

  int compared;
  int mismatched;

  logic [1:0] model_s;
  logic [1:0] exp_q[$];

  tff_cascade #(.STAGES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed s=%b expected s=%b", tag, obs, exp);
    end
  endtask

  // Drive data between edges, advance the model at the edge, compare just after.
  task automatic cycle(input logic d, input string tag);
    logic [1:0] nxt;
    data = d;
    @(posedge clk);
    nxt[0] = model_s[0] ^ d;
    nxt[1] = model_s[1] ^ model_s[0];
    model_s = nxt;
    exp_q.push_back(model_s);
    #1;
    check(tag, {q, dut.s[0]}, exp_q.pop_front());
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    model_s = 2'b00;
    #1;
    check(tag, {q, dut.s[0]}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_s    = 2'b00;
    rst        = 1'b0;
    data       = 1'b0;

    #2;
    check("reset_before_edge", {q, dut.s[0]}, 2'b00);
    @(posedge clk);
    #1;
    check("reset_across_edge", {q, dut.s[0]}, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    cycle(1'b0, "idle_15");
    cycle(1'b0, "idle_25");

    cycle(1'b1, "pulse2_35");
    cycle(1'b1, "pulse2_45");
    cycle(1'b0, "pulse2_55");
    cycle(1'b0, "pulse2_65");

    // q is 1 here; reset between edges must clear it without a clock.
    async_reset("async_reset_mid");
    cycle(1'b0, "after_release");

    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, $sformatf("continuous_%0d", i));
    end

    async_reset("async_reset_2");
    cycle(1'b1, "single_pulse");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, $sformatf("after_single_%0d", i));
    end

    // A data glitch that returns low before the edge must not be seen.
    async_reset("async_reset_3");
    #2;
    data = 1'b1;
    #2;
    data = 1'b0;
    cycle(1'b0, "glitch_ignored");

    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_tff_cascade
